// File: rtl/mdu_div.sv
// Multi-cycle signed/unsigned restoring divider returning {hi=remainder, lo=quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips iteration and completes in one cycle.
module mdu_div #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_div,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             annul,
   output logic             stall,
   output logic             ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;

   logic             accept;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   rem_sh, rem_sub;
   logic [WIDTH-1:0] res_hi, res_lo;

   // Partial remainder is kept one bit wider during the compare so that divisors with the
   // top bit set (unsigned) cannot overflow the shifted remainder.
   always_comb begin
      accept  = start & ~annul;
      abs_a   = (signed_div & opa[WIDTH-1]) ? -opa : opa;
      abs_b   = (signed_div & opb[WIDTH-1]) ? -opb : opb;
      rem_sh  = {rem_q, dvd_q[WIDTH-1]};
      rem_sub = rem_sh - {1'b0, dvs_q};
      res_lo  = dz_q ? '1 : (qneg_q ? -dvd_q : dvd_q);
      res_hi  = rneg_q ? -rem_q : rem_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               rem_d   = '0;
               dvd_d   = abs_a;
               dvs_d   = abs_b;
               qneg_d  = signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
               rneg_d  = signed_div & opa[WIDTH-1];
               dz_d    = (opb == '0);
               cnt_d   = '0;
               state_d = StBusy;
`ifdef DIV_ZERO_FAST_EN
               // Iterating by zero leaves rem=|opa|; preload it so the result is identical.
               if (opb == '0) begin
                  rem_d   = abs_a;
                  state_d = StDone;
               end
`else
`endif
            end
         end
         StBusy: begin
            if (annul) begin
               state_d = StIdle;
            end else begin
               rem_d = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], ~rem_sub[WIDTH]};
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == LastCnt) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
            if (!annul) begin
               hi_d = res_hi;
               lo_d = res_lo;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      stall = rst & ((state_q == StBusy) | ((state_q == StIdle) & accept));
      ready = (state_q == StDone) & ~annul;
      hi    = ready ? res_hi : hi_q;
      lo    = ready ? res_lo : lo_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end

endmodule

// File: tb/tb_mdu_div.sv
// Self-checking bench for mdu_div: directed cases plus random operands against an
// arithmetic reference model.
module tb_mdu_div;

   localparam int WIDTH = 32;

   logic              clk;
   logic              rst;
   logic              start;
   logic              signed_div;
   logic [WIDTH-1:0]  opa;
   logic [WIDTH-1:0]  opb;
   logic              annul;
   logic              stall;
   logic              ready;
   logic [WIDTH-1:0]  hi;
   logic [WIDTH-1:0]  lo;

   int                checks;
   int                failures;
   logic [WIDTH-1:0]  exp_hi;
   logic [WIDTH-1:0]  exp_lo;

   mdu_div #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_div (signed_div),
      .opa        (opa),
      .opb        (opb),
      .annul      (annul),
      .stall      (stall),
      .ready      (ready),
      .hi         (hi),
      .lo         (lo)
   );

   always #5 clk = ~clk;

   function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      if (b == 32'h0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!s) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'h0;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
   endfunction

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Issues one op at the next cycle (cycle 0) and checks every cycle through lat+1.
   task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eq;
      logic [31:0] er;
      int          lat;
      model(s, a, b, eq, er);
      lat = WIDTH + 1;
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'h0) lat = 1;
`else
`endif
      @(negedge clk);
      start = 1'b1; signed_div = s; opa = a; opb = b; annul = 1'b0;
      #1;
      chk1("stall_c0", stall, 1'b1);
      chk1("ready_c0", ready, 1'b0);
      for (int c = 1; c <= lat + 1; c++) begin
         @(negedge clk);
         start = (c < lat);
         // Operands are latched at accept; scrambling them must not matter.
         opa = $urandom;
         opb = $urandom;
         signed_div = 1'($urandom_range(0, 1));
         #1;
         if (c == lat) begin
            exp_hi = er;
            exp_lo = eq;
         end
         chk1("stall", stall, (c < lat));
         chk1("ready", ready, (c == lat));
         chk32("hi", hi, exp_hi);
         chk32("lo", lo, exp_lo);
      end
   endtask

   initial begin
      logic        rs;
      logic [31:0] ra;
      logic [31:0] rb;
      int          sel;
      checks = 0; failures = 0;
      clk = 1'b0; rst = 1'b0; start = 1'b0; signed_div = 1'b0;
      opa = '0; opb = '0; annul = 1'b0;
      exp_hi = '0; exp_lo = '0;

      // Reset state, including start held high during reset.
      repeat (2) @(negedge clk);
      start = 1'b1;
      #1;
      chk1("rst_stall", stall, 1'b0);
      chk1("rst_ready", ready, 1'b0);
      chk32("rst_hi", hi, 32'h0);
      chk32("rst_lo", lo, 32'h0);
      @(negedge clk);
      start = 1'b0;
      rst = 1'b1;

      do_op(1'b0, 32'd100, 32'd7);
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2);
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op(1'b0, 32'd5, 32'd0);
      do_op(1'b1, 32'hFFFF_FFF9, 32'd0);
      do_op(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);

      // Annul in BUSY at cycle 10, then a fresh op starting in cycle 12.
      @(negedge clk);
      start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3; annul = 1'b0;
      #1;
      chk1("an_stall_c0", stall, 1'b1);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         annul = (c == 10);
         #1;
         chk1("an_stall_busy", stall, 1'b1);
         chk1("an_ready_busy", ready, 1'b0);
      end
      @(negedge clk);
      start = 1'b0; annul = 1'b0;
      #1;
      chk1("an_stall_c11", stall, 1'b0);
      chk1("an_ready_c11", ready, 1'b0);
      chk32("an_hi_c11", hi, exp_hi);
      chk32("an_lo_c11", lo, exp_lo);
      do_op(1'b0, 32'd100, 32'd7);

      // start together with annul in IDLE: nothing accepted.
      @(negedge clk);
      start = 1'b1; annul = 1'b1; opa = 32'd9; opb = 32'd2;
      #1;
      chk1("sa_stall", stall, 1'b0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         start = 1'b0; annul = 1'b0;
         #1;
         chk1("sa_stall_after", stall, 1'b0);
         chk1("sa_ready_after", ready, 1'b0);
      end

      // Annul in the DONE cycle: ready suppressed, hi/lo keep the previous result.
      @(negedge clk);
      start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3; annul = 1'b0;
      for (int c = 1; c <= WIDTH + 2; c++) begin
         @(negedge clk);
         start = (c < WIDTH + 1);
         annul = (c == WIDTH + 1);
         #1;
         chk1("ad_ready", ready, 1'b0);
         chk32("ad_hi", hi, exp_hi);
         chk32("ad_lo", lo, exp_lo);
      end
      annul = 1'b0;

      // Reset asserted mid-BUSY (cycle 20).
      @(negedge clk);
      start = 1'b1; signed_div = 1'b1; opa = 32'hFFFF_FF00; opb = 32'd5;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 20) rst = 1'b0;
         #1;
      end
      exp_hi = '0;
      exp_lo = '0;
      chk1("mr_stall", stall, 1'b0);
      chk1("mr_ready", ready, 1'b0);
      chk32("mr_hi", hi, 32'h0);
      chk32("mr_lo", lo, 32'h0);
      @(negedge clk);
      start = 1'b0;
      rst = 1'b1;
      #1;
      chk1("mr_stall_rel", stall, 1'b0);
      do_op(1'b1, 32'hFFFF_FF00, 32'd5);

      // Random operands with a bias toward the corner cases.
      for (int i = 0; i < 40; i++) begin
         rs  = 1'($urandom_range(0, 1));
         ra  = $urandom;
         rb  = $urandom;
         sel = int'($urandom_range(0, 7));
         case (sel)
            0: rb = 32'h0;
            1: rb = $urandom_range(1, 15);
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3: ra = $urandom_range(0, 100);
            4: rb = ra >> $urandom_range(0, 31);
            default: ;
         endcase
         do_op(rs, ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
